// File: rtl/kappa3_mem_pkg.sv
// -----------------------------------------------------------------------------
// kappa3_mem_pkg
// Shared definitions for the load/store access controller:
//   - funct3 encodings of the supported load/store widths
//   - FSM state encoding of mem_access_ctrl
//   - req_legal(): decides whether a latched request may reach memory
// No ports (package).
// -----------------------------------------------------------------------------
package kappa3_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // A request is legal when its width exists for its direction and the
  // address is naturally aligned for that width.
  function automatic logic req_legal(input logic [2:0] f3,
                                     input logic       we,
                                     input logic [1:0] addr_lo);
    logic f3_ok;
    logic align_ok;
    if (we) begin
      f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
    end
    case (f3[1:0])
      2'b01:   align_ok = (addr_lo[0] == 1'b0);
      2'b10:   align_ok = (addr_lo == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return f3_ok && align_ok;
  endfunction

endpackage

// File: rtl/mem_lane_conv.sv
// -----------------------------------------------------------------------------
// mem_lane_conv
// Purely combinational byte-lane logic between the core-side view (right
// aligned data, byte address) and the memory-side view (word bus + enables).
// Ports:
//   funct3_i     in  3   access width / signedness
//   addr_lo_i    in  2   byte offset within the word
//   wdata_i      in  32  right-aligned store data
//   mem_rdata_i  in  32  word read from memory
//   wrbits_o     out 4   byte enables for a store of this width/offset
//   wdata_rep_o  out 32  store data replicated across all lanes
//   rdata_ext_o  out 32  selected load lane, sign/zero extended
// -----------------------------------------------------------------------------
module mem_lane_conv
  import kappa3_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  wrbits_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_ext_o
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = mem_rdata_i[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = mem_rdata_i[16*gi +: 16];
    end
  endgenerate

  // Store side: enables and lane replication.
  always_comb begin
    wrbits_o    = 4'b0000;
    wdata_rep_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        wrbits_o    = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        wrbits_o    = 4'b0011 << addr_lo_i;
        wdata_rep_o = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        wrbits_o    = 4'b1111;
        wdata_rep_o = wdata_i;
      end
      default: begin
        wrbits_o    = 4'b0000;
        wdata_rep_o = wdata_i;
      end
    endcase
  end

  // Load side: pick the lane, then extend. funct3[2] set means unsigned.
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        sign_ext;

  always_comb begin
    sel_byte    = byte_lane[addr_lo_i];
    sel_half    = half_lane[addr_lo_i[1]];
    sign_ext    = ~funct3_i[2];
    rdata_ext_o = mem_rdata_i;
    case (funct3_i[1:0])
      2'b00:   rdata_ext_o = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      2'b01:   rdata_ext_o = {{16{sign_ext & sel_half[15]}}, sel_half};
      default: rdata_ext_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Single-outstanding load/store controller. A start pulse in IDLE latches the
// request; legal requests run one memory cycle (with timeout), illegal ones
// finish immediately with err. done pulses for one cycle at completion.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            request pulse (only seen in IDLE)
//   ir_i[31:0]         instruction word, funct3 = ir_i[14:12]
//   we_i               1 = store, 0 = load
//   addr_i[31:0]       byte address
//   wdata_i[31:0]      right-aligned store data
//   busy_o             not IDLE
//   done_o             one-cycle completion pulse
//   err_o              error flag, held until the next accepted start
//   rdata_o[31:0]      converted load result, held
//   mem_req_o          memory request, high throughout ACCESS
//   mem_we_o           write qualifier
//   mem_addr_o[31:0]   word-aligned address
//   mem_wdata_o[31:0]  lane-replicated store data
//   mem_wrbits_o[3:0]  byte enables
//   mem_ack_i          memory completion
//   mem_rdata_i[31:0]  memory read word, valid with mem_ack_i
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import kappa3_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] ir_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wrbits_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept;
  logic        legal;
  logic        timed_out;
  logic [3:0]  lane_wrbits;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  // Only funct3 of the instruction word is relevant here.
  logic unused_ir;
  assign unused_ir = ^{ir_i[31:15], ir_i[11:0]};

  assign accept    = (state_q == ST_IDLE) && start_i;
  assign legal     = req_legal(ir_i[14:12], we_i, addr_i[1:0]);
  assign timed_out = (cnt_q == TIMEOUT_CNT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = legal ? ST_ACCESS : ST_DONE;
        end
      end
      ST_ACCESS: begin
        if (mem_ack_i || timed_out) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o       = (state_q != ST_IDLE);
    done_o       = (state_q == ST_DONE);
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_wrbits_o = 4'b0000;
    if (state_q == ST_ACCESS) begin
      mem_req_o    = 1'b1;
      mem_we_o     = we_q;
      mem_wrbits_o = we_q ? lane_wrbits : 4'b0000;
    end
  end

  // Address and data follow the latched request; they only matter while
  // mem_req_o is high.
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_wdata_o = lane_wdata;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;

  // ---------------------------------------------------------------------------
  // Request latches, wait counter and result registers
  // ---------------------------------------------------------------------------
  always_comb begin
    f3_d    = f3_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (accept) begin
      f3_d    = ir_i[14:12];
      we_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      cnt_d   = 4'd0;
      // Illegal requests skip ACCESS, so their error is known right away.
      err_d   = ~legal;
    end else if (state_q == ST_ACCESS) begin
      if (mem_ack_i) begin
        err_d = 1'b0;
        if (!we_q) begin
          rdata_d = lane_rdata;
        end
      end else if (timed_out) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      f3_q    <= f3_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane conversion
  // ---------------------------------------------------------------------------
  mem_lane_conv u_lane (
    .funct3_i    (f3_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .mem_rdata_i (mem_rdata_i),
    .wrbits_o    (lane_wrbits),
    .wdata_rep_o (lane_wdata),
    .rdata_ext_o (lane_rdata)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed transactions with hand-computed results. Each issued request
// pushes its expected completion onto a queue; a monitor process pops and
// checks it whenever done_o is seen.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ir = 32'd0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h5A5A5A5A;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wrbits;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_total = 0;
  int done_total = 0;

  typedef struct {
    string       nm;
    logic        e_err;
    logic [31:0] e_rdata;
    int          issue;
    int          e_lat;
  } exp_t;

  exp_t exp_q[$];

  mem_access_ctrl #(.TIMEOUT(15)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start),
    .ir_i         (ir),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .rdata_o      (rdata),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wrbits_o (mem_wrbits),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, expv);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expectation.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_total++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
        end else begin
          e = exp_q.pop_front();
          chk({e.nm, "_err"}, 32'(err), 32'(e.e_err));
          chk({e.nm, "_rdata"}, rdata, e.e_rdata);
          chk({e.nm, "_latency"}, 32'(cyc - e.issue), 32'(e.e_lat));
          $display("txn %-10s err=%0b rdata=%h latency=%0d", e.nm, err, rdata, cyc - e.issue);
        end
      end
    end
  endtask

  task automatic count_req();
    forever begin
      @(negedge clk);
      if (mem_req) req_total++;
    end
  endtask

  // One transaction. ack_wait = ACCESS cycles before ack (-1: never ack).
  task automatic run(input string nm, input logic [2:0] f3, input logic w,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] mrd, input int ack_wait, input logic legal,
                     input logic [31:0] e_addr, input logic [3:0] e_bits,
                     input logic [31:0] e_wdata, input logic e_err,
                     input logic [31:0] e_rdata, input int e_lat, input logic poke);
    int   req0, done0, n, e_req;
    exp_t e;
    @(negedge clk);
    ir    = (32'hA5A50F73 & ~32'h00007000) | ({29'd0, f3} << 12);
    we    = w;
    addr  = a;
    wdata = wd;
    start = 1'b1;
    req0  = req_total;
    done0 = done_total;
    e.nm = nm; e.e_err = e_err; e.e_rdata = e_rdata; e.issue = cyc; e.e_lat = e_lat;
    exp_q.push_back(e);
    @(negedge clk);
    // Scramble inputs: the accepted request must not follow them.
    start = 1'b0;
    ir    = ~ir;
    we    = ~w;
    addr  = ~a;
    wdata = ~wd;
    if (legal) begin
      chk({nm, "_mem_req"}, 32'(mem_req), 32'd1);
      chk({nm, "_mem_we"}, 32'(mem_we), 32'(w));
      chk({nm, "_mem_addr"}, mem_addr, e_addr);
      chk({nm, "_wrbits"}, 32'(mem_wrbits), 32'(e_bits));
      if (w) chk({nm, "_mem_wdata"}, mem_wdata, e_wdata);
      if (ack_wait >= 0) begin
        for (int k = 0; k < ack_wait; k++) begin
          start = (poke && k == 0);
          @(negedge clk);
        end
        start     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = mrd;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A5A5A;
      end
    end
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({nm, "_finish_bound"}, 32'(busy), 32'd0);
    e_req = !legal ? 0 : ((ack_wait < 0) ? 16 : ack_wait + 1);
    chk({nm, "_req_cycles"}, 32'(req_total - req0), 32'(e_req));
    chk({nm, "_done_count"}, 32'(done_total - done0), 32'd1);
    chk({nm, "_req_after"}, 32'(mem_req), 32'd0);
    chk({nm, "_wrbits_after"}, 32'(mem_wrbits), 32'd0);
  endtask

  initial begin
    int done0;
    fork
      monitor();
      count_req();
    join_none

    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wrbits", 32'(mem_wrbits), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    //   name    f3      we    addr          wdata         mem_rdata     wait legal mem_addr      bits     mem_wdata     err   rdata         lat poke
    run("SB",    3'b000, 1'b1, 32'h00001003, 32'h000000A5, 32'h0,        0,  1'b1, 32'h00001000, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h00000000, 2,  1'b0);
    run("LB",    3'b000, 1'b0, 32'h00002001, 32'h0,        32'h1234F600, 0,  1'b1, 32'h00002000, 4'b0000, 32'h0,        1'b0, 32'hFFFFFFF6, 2,  1'b0);
    run("LBU",   3'b100, 1'b0, 32'h00002001, 32'h0,        32'h1234F600, 0,  1'b1, 32'h00002000, 4'b0000, 32'h0,        1'b0, 32'h000000F6, 2,  1'b0);
    run("LH",    3'b001, 1'b0, 32'h00002002, 32'h0,        32'h8001ABCD, 0,  1'b1, 32'h00002000, 4'b0000, 32'h0,        1'b0, 32'hFFFF8001, 2,  1'b0);
    run("LHU",   3'b101, 1'b0, 32'h00002002, 32'h0,        32'h8001ABCD, 0,  1'b1, 32'h00002000, 4'b0000, 32'h0,        1'b0, 32'h00008001, 2,  1'b0);
    run("LW",    3'b010, 1'b0, 32'h00002004, 32'h0,        32'hDEADBEEF, 2,  1'b1, 32'h00002004, 4'b0000, 32'h0,        1'b0, 32'hDEADBEEF, 4,  1'b0);
    run("LB3",   3'b000, 1'b0, 32'h00002003, 32'h0,        32'h7F123456, 1,  1'b1, 32'h00002000, 4'b0000, 32'h0,        1'b0, 32'h0000007F, 3,  1'b0);
    run("SH_poke",3'b001,1'b1, 32'h00001002, 32'h1234BEEF, 32'h0,        3,  1'b1, 32'h00001000, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0000007F, 5,  1'b1);
    run("SW",    3'b010, 1'b1, 32'h00003000, 32'hCAFEF00D, 32'h0,        0,  1'b1, 32'h00003000, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0000007F, 2,  1'b0);
    run("SW_mis",3'b010, 1'b1, 32'h00003002, 32'h11111111, 32'h0,        0,  1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000007F, 1,  1'b0);
    run("LH_mis",3'b001, 1'b0, 32'h00002001, 32'h0,        32'h0,        0,  1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000007F, 1,  1'b0);
    run("LW_mis",3'b010, 1'b0, 32'h00002002, 32'h0,        32'h0,        0,  1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000007F, 1,  1'b0);
    run("L_f3_3",3'b011, 1'b0, 32'h00002000, 32'h0,        32'h0,        0,  1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000007F, 1,  1'b0);
    run("L_f3_6",3'b110, 1'b0, 32'h00002000, 32'h0,        32'h0,        0,  1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000007F, 1,  1'b0);
    run("S_f3_4",3'b100, 1'b1, 32'h00002000, 32'h0,        32'h0,        0,  1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000007F, 1,  1'b0);
    run("SH_tmo",3'b001, 1'b1, 32'h00004000, 32'h000055AA, 32'h0,        -1, 1'b1, 32'h00004000, 4'b0011, 32'h55AA55AA, 1'b1, 32'h0000007F, 17, 1'b0);
    run("LHU_lo",3'b101, 1'b0, 32'h00002000, 32'h0,        32'h1111F00F, 0,  1'b1, 32'h00002000, 4'b0000, 32'h0,        1'b0, 32'h0000F00F, 2,  1'b0);
    run("SB1",   3'b000, 1'b1, 32'h00001001, 32'h00000C3C, 32'h0,        0,  1'b1, 32'h00001000, 4'b0010, 32'h3C3C3C3C, 1'b0, 32'h0000F00F, 2,  1'b0);

    // mem_ack while idle must be ignored.
    @(negedge clk);
    done0     = done_total;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h5A5A5A5A;
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_rdata", rdata, 32'h0000F00F);
    chk("idle_ack_done", 32'(done_total - done0), 32'd0);

    // Reset in the middle of ACCESS: request drops at once, no done.
    @(negedge clk);
    ir    = 32'h00000000;
    we    = 1'b1;
    addr  = 32'h00006001;
    wdata = 32'h00000011;
    start = 1'b1;
    done0 = done_total;
    @(negedge clk);
    start = 1'b0;
    chk("midrst_req_before", 32'(mem_req), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_wrbits", 32'(mem_wrbits), 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 32'(done_total - done0), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    run("LW_post",3'b010,1'b0, 32'h00005000, 32'h0,        32'h01234567, 0,  1'b1, 32'h00005000, 4'b0000, 32'h0,        1'b0, 32'h01234567, 2,  1'b0);

    repeat (2) @(negedge clk);
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
